// File: rtl/apb_pkg.sv
// Shared APB completer definitions: FSM encoding, bus widths
// and bit positions of the individual error causes.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_RDONLY   = 2;
    localparam int ERR_W        = 3;

endpackage

// File: rtl/apb_regfile.sv
// Byte-strobed word array; word 0 is a constant ID, the rest
// are async-cleared flops with a combinational read port.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                    DEPTH    = 16,
    parameter int                    IDX_W    = 4,
    parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA0B0_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      widx_i,
    input  logic [APB_DATA_W-1:0] wdata_i,
    input  logic [APB_STRB_W-1:0] wstrb_i,
    input  logic [IDX_W-1:0]      ridx_i,
    output logic [APB_DATA_W-1:0] rdata_o
);

    logic [APB_DATA_W-1:0] words [DEPTH];

    assign words[0] = ID_VALUE;

    for (genvar i = 1; i < DEPTH; i++) begin : g_word
        logic [APB_DATA_W-1:0] word_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                word_q <= '0;
            end else if (we_i && widx_i == IDX_W'(i)) begin
                for (int b = 0; b < APB_STRB_W; b++) begin
                    if (wstrb_i[b]) begin
                        word_q[8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end

        assign words[i] = word_q;
    end

    assign rdata_o = (32'(ridx_i) < DEPTH) ? words[ridx_i] : '0;

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: wait-state FSM, access decode and error check
// in front of the byte-strobed register array.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DEPTH       = 16,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA0B0_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    input  logic [APB_STRB_W-1:0] pstrb,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [APB_DATA_W-1:0] pwdata_q;
    logic [APB_STRB_W-1:0] pstrb_q;
    logic [APB_DATA_W-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;

    logic                  latch;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_write;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [ERR_W-1:0]      err_cause;
    logic                  rf_we;
    logic [APB_DATA_W-1:0] rf_rdata;

    // With zero wait states RESP is entered from IDLE, before the
    // access is latched, so decode from the live bus in that case.
    assign acc_addr  = (state_q == ST_IDLE) ? paddr : paddr_q;
    assign acc_write = (state_q == ST_IDLE) ? pwrite : pwrite_q;
    assign word_idx  = acc_addr[ADDR_WIDTH-1:2];

    assign err_cause[ERR_MISALIGN] = |acc_addr[1:0];
    assign err_cause[ERR_RANGE]    = 32'(word_idx) >= DEPTH;
    assign err_cause[ERR_RDONLY]   = acc_write && (word_idx == '0);

    assign rf_we = (state_q == ST_RESP) && pwrite_q && !pslverr_q;

    apb_regfile #(
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we_i    (rf_we),
        .widx_i  (paddr_q[IDX_W+1:2]),
        .wdata_i (pwdata_q),
        .wstrb_i (pstrb_q),
        .ridx_i  (word_idx[IDX_W-1:0]),
        .rdata_o (rf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!(psel && penable)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        if (enter_resp) begin
            pslverr_d = |err_cause;
            prdata_d  = (|err_cause || acc_write) ? '0 : rf_rdata;
        end else if (state_q == ST_RESP) begin
            pslverr_d = 1'b0;
            prdata_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            if (latch) begin
                paddr_q  <= paddr;
                pwrite_q <= pwrite;
                pwdata_q <= pwdata;
                pstrb_q  <= pstrb;
            end
        end
    end

    assign pready  = (state_q == ST_RESP);
    assign prdata  = prdata_q;
    assign pslverr = pslverr_q;

endmodule
